// File: rtl/bcd_serial_alu.sv
// Digit-serial BCD ALU with four-phase command handshake: loads/displays ack one edge after
// capture, ADD/SUB ack after DIGITS edges; CMD_ACK then holds until CMD_REQ is seen low.
module bcd_serial_alu #(
   parameter int DIGITS = 4,
   parameter int SELW   = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      sw,
   input  logic [2:0]      cmd,
   input  logic [SELW-1:0] byte_sel,
   input  logic            cmd_req,
   output logic            cmd_ack,
   output logic [7:0]      led,
   output logic            busy,
   output logic            carry,
   output logic            err
);

   localparam int W     = DIGITS * 4;
   localparam int PAIRS = DIGITS / 2;
   localparam int CNTW  = $clog2(DIGITS);

   localparam logic [2:0] C_INIT   = 3'd0;
   localparam logic [2:0] C_LOAD_A = 3'd1;
   localparam logic [2:0] C_LOAD_B = 3'd2;
   localparam logic [2:0] C_ADD    = 3'd3;
   localparam logic [2:0] C_SUB    = 3'd4;
   localparam logic [2:0] C_DISP_A = 3'd5;
   localparam logic [2:0] C_DISP_B = 3'd6;
   localparam logic [2:0] C_DISP_R = 3'd7;

   typedef enum logic [1:0] {IDLE, EXEC, ARITH, ACKW} state_t;

   state_t state, state_nxt;

   logic [W-1:0]    a, b, r;
   logic [2:0]      cmd_q;
   logic [SELW-1:0] sel_q;
   logic [7:0]      sw_q;
   logic [CNTW-1:0] cnt;
   logic            c;

   logic [3:0] a_dig, b_dig, b_op, r_dig;
   logic [4:0] d, d_adj;
   logic       c_out, last;
   logic [7:0] a_pair, b_pair, r_pair;
   logic       sel_ok, bcd_ok;

   // Operand digit selected by the serial counter.
   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (cnt == CNTW'(i)) begin
            a_dig = a[i*4 +: 4];
            b_dig = b[i*4 +: 4];
         end
      end
   end

   // SUB adds the nine's complement of B with carry-in 1, giving ten's complement.
   always_comb begin
      b_op  = (cmd_q == C_SUB) ? (4'd9 - b_dig) : b_dig;
      d     = {1'b0, a_dig} + {1'b0, b_op} + {4'b0000, c};
      d_adj = d + 5'd6;
      if (d > 5'd9) begin
         r_dig = d_adj[3:0];
         c_out = 1'b1;
      end else begin
         r_dig = d[3:0];
         c_out = 1'b0;
      end
      last = (cnt == CNTW'(DIGITS - 1));
   end

   always_comb begin
      a_pair = '0;
      b_pair = '0;
      r_pair = '0;
      sel_ok = 1'b0;
      for (int i = 0; i < PAIRS; i++) begin
         if (sel_q == SELW'(i)) begin
            a_pair = a[i*8 +: 8];
            b_pair = b[i*8 +: 8];
            r_pair = r[i*8 +: 8];
            sel_ok = 1'b1;
         end
      end
      bcd_ok = (sw_q[7:4] <= 4'd9) && (sw_q[3:0] <= 4'd9);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_req) state_nxt = (cmd == C_ADD || cmd == C_SUB) ? ARITH : EXEC;
         EXEC:    state_nxt = ACKW;
         ARITH:   if (last) state_nxt = ACKW;
         ACKW:    if (!cmd_req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      cmd_ack = (state == ACKW);
      busy    = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a     <= '0;
         b     <= '0;
         r     <= '0;
         led   <= '0;
         carry <= 1'b0;
         err   <= 1'b0;
         cmd_q <= '0;
         sel_q <= '0;
         sw_q  <= '0;
         cnt   <= '0;
         c     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_req) begin
                  cmd_q <= cmd;
                  sel_q <= byte_sel;
                  sw_q  <= sw;
                  cnt   <= '0;
                  c     <= (cmd == C_SUB);
               end
            end
            EXEC: begin
               case (cmd_q)
                  C_INIT: begin
                     a     <= '0;
                     b     <= '0;
                     r     <= '0;
                     led   <= '0;
                     carry <= 1'b0;
                     err   <= 1'b0;
                  end
                  C_LOAD_A: begin
                     if (!sel_ok || !bcd_ok) err <= 1'b1;
                     else
                        for (int i = 0; i < PAIRS; i++)
                           if (sel_q == SELW'(i)) a[i*8 +: 8] <= sw_q;
                  end
                  C_LOAD_B: begin
                     if (!sel_ok || !bcd_ok) err <= 1'b1;
                     else
                        for (int i = 0; i < PAIRS; i++)
                           if (sel_q == SELW'(i)) b[i*8 +: 8] <= sw_q;
                  end
                  C_DISP_A: if (!sel_ok) err <= 1'b1; else led <= a_pair;
                  C_DISP_B: if (!sel_ok) err <= 1'b1; else led <= b_pair;
                  C_DISP_R: if (!sel_ok) err <= 1'b1; else led <= r_pair;
                  default: ;
               endcase
            end
            ARITH: begin
               for (int i = 0; i < DIGITS; i++)
                  if (cnt == CNTW'(i)) r[i*4 +: 4] <= r_dig;
               c   <= c_out;
               cnt <= cnt + 1'b1;
               if (last) carry <= (cmd_q == C_SUB) ? ~c_out : c_out;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Randomized and directed checks of bcd_serial_alu against a decimal-integer reference model.
module tb_bcd_serial_alu;

   localparam int DIGITS = 4;
   localparam int SELW   = 2;

   localparam logic [2:0] C_INIT   = 3'd0;
   localparam logic [2:0] C_LOAD_A = 3'd1;
   localparam logic [2:0] C_LOAD_B = 3'd2;
   localparam logic [2:0] C_ADD    = 3'd3;
   localparam logic [2:0] C_SUB    = 3'd4;
   localparam logic [2:0] C_DISP_A = 3'd5;
   localparam logic [2:0] C_DISP_B = 3'd6;
   localparam logic [2:0] C_DISP_R = 3'd7;

   logic            clk, rst_n;
   logic [7:0]      sw;
   logic [2:0]      cmd;
   logic [SELW-1:0] byte_sel;
   logic            cmd_req, cmd_ack;
   logic [7:0]      led;
   logic            busy, carry, err;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: operands and result as plain decimal integers.
   int         ma, mb, mr;
   logic [7:0] mled;
   logic       mcarry, merr;

   bcd_serial_alu #(.DIGITS(DIGITS), .SELW(SELW)) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .cmd(cmd), .byte_sel(byte_sel),
      .cmd_req(cmd_req), .cmd_ack(cmd_ack), .led(led), .busy(busy),
      .carry(carry), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd8(input int p);
      return 8'(((p / 10) % 10) * 16 + (p % 10));
   endfunction

   function automatic int pair_of(input int x, input int s);
      return (x / ((s == 0) ? 1 : 100)) % 100;
   endfunction

   function automatic int set_pair(input int x, input int s, input int p);
      int pw;
      pw = (s == 0) ? 1 : 100;
      return x - pair_of(x, s) * pw + p * pw;
   endfunction

   task automatic model_reset();
      ma = 0; mb = 0; mr = 0; mled = '0; mcarry = 1'b0; merr = 1'b0;
   endtask

   task automatic model(input logic [2:0] c, input int s, input logic [7:0] w);
      int  hi, lo;
      bit  bad_sel;
      hi = int'(w[7:4]);
      lo = int'(w[3:0]);
      bad_sel = (s >= DIGITS / 2);
      case (c)
         C_INIT:   model_reset();
         C_LOAD_A: if (bad_sel || hi > 9 || lo > 9) merr = 1'b1; else ma = set_pair(ma, s, hi * 10 + lo);
         C_LOAD_B: if (bad_sel || hi > 9 || lo > 9) merr = 1'b1; else mb = set_pair(mb, s, hi * 10 + lo);
         C_ADD: begin
            mcarry = ((ma + mb) >= 10000);
            mr = (ma + mb) % 10000;
         end
         C_SUB: begin
            mcarry = (ma < mb);
            mr = (ma - mb + 10000) % 10000;
         end
         C_DISP_A: if (bad_sel) merr = 1'b1; else mled = to_bcd8(pair_of(ma, s));
         C_DISP_B: if (bad_sel) merr = 1'b1; else mled = to_bcd8(pair_of(mb, s));
         C_DISP_R: if (bad_sel) merr = 1'b1; else mled = to_bcd8(pair_of(mr, s));
         default: ;
      endcase
   endtask

   // One full four-phase transaction; hold keeps CMD_REQ high extra cycles after the ack.
   task automatic do_cmd(input logic [2:0] c, input int s, input logic [7:0] w, input int hold);
      int n;
      bit got;
      @(negedge clk);
      cmd = c; byte_sel = SELW'(s); sw = w; cmd_req = 1'b1;
      n = 0; got = 0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check_eq("busy_run", 32'(busy), 32'd1);
            cmd = 3'($urandom); byte_sel = SELW'($urandom); sw = 8'($urandom);
         end
         if (cmd_ack) got = 1;
      end
      check_eq("ack_seen", 32'(got), 32'd1);
      check_eq("ack_latency", 32'(n - 1), 32'((c == C_ADD || c == C_SUB) ? DIGITS : 1));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("ack_hold", 32'(cmd_ack), 32'd1);
         check_eq("busy_hold", 32'(busy), 32'd1);
      end
      cmd_req = 1'b0;
      @(negedge clk);
      check_eq("ack_drop", 32'(cmd_ack), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      model(c, s, w);
      check_eq("carry", 32'(carry), 32'(mcarry));
      check_eq("err", 32'(err), 32'(merr));
      check_eq("led", 32'(led), 32'(mled));
   endtask

   task automatic load_ab(input logic [15:0] av, input logic [15:0] bv);
      do_cmd(C_LOAD_A, 0, av[7:0], 0);
      do_cmd(C_LOAD_A, 1, av[15:8], 0);
      do_cmd(C_LOAD_B, 0, bv[7:0], 0);
      do_cmd(C_LOAD_B, 1, bv[15:8], 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] c;
      int         s;
      logic [7:0] w;

      rst_n = 1'b0; cmd_req = 1'b0; cmd = '0; byte_sel = '0; sw = '0;
      model_reset();
      #12;
      check_eq("rst_ack", 32'(cmd_ack), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_led", 32'(led), 32'd0);
      check_eq("rst_carry", 32'(carry), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1234 + 5678 = 6912
      load_ab(16'h1234, 16'h5678);
      do_cmd(C_ADD, 0, 8'h00, 0);
      check_eq("add1_carry", 32'(carry), 32'd0);
      do_cmd(C_DISP_R, 0, 8'h00, 0);
      check_eq("add1_r_lo", 32'(led), 32'h12);
      do_cmd(C_DISP_R, 1, 8'h00, 0);
      check_eq("add1_r_hi", 32'(led), 32'h69);

      load_ab(16'h9999, 16'h0001);
      do_cmd(C_ADD, 0, 8'h00, 0);
      check_eq("add2_carry", 32'(carry), 32'd1);
      do_cmd(C_DISP_R, 1, 8'h00, 0);
      check_eq("add2_r_hi", 32'(led), 32'h00);

      load_ab(16'h0100, 16'h0200);
      do_cmd(C_SUB, 0, 8'h00, 0);
      check_eq("sub1_carry", 32'(carry), 32'd1);
      do_cmd(C_DISP_R, 1, 8'h00, 0);
      check_eq("sub1_r_hi", 32'(led), 32'h99);

      load_ab(16'h0500, 16'h0123);
      do_cmd(C_SUB, 0, 8'h00, 0);
      check_eq("sub2_carry", 32'(carry), 32'd0);
      do_cmd(C_DISP_R, 0, 8'h00, 0);
      check_eq("sub2_r_lo", 32'(led), 32'h77);
      do_cmd(C_DISP_R, 1, 8'h00, 0);
      check_eq("sub2_r_hi", 32'(led), 32'h03);

      // Invalid BCD and out-of-range selects
      do_cmd(C_DISP_A, 1, 8'h00, 0);
      do_cmd(C_LOAD_A, 1, 8'h3A, 0);
      check_eq("bad_bcd_err", 32'(err), 32'd1);
      do_cmd(C_DISP_A, 1, 8'h00, 0);
      check_eq("bad_bcd_a_kept", 32'(led), 32'h05);
      do_cmd(C_DISP_A, 2, 8'h00, 0);
      check_eq("bad_sel_led", 32'(led), 32'h05);
      do_cmd(C_LOAD_B, 3, 8'h42, 0);
      do_cmd(C_DISP_B, 0, 8'h00, 0);
      do_cmd(C_INIT, 0, 8'h00, 0);
      check_eq("init_err", 32'(err), 32'd0);
      check_eq("init_led", 32'(led), 32'd0);

      for (int k = 0; k < 80; k++) begin
         c = 3'($urandom_range(0, 7));
         if (c == C_INIT && ($urandom % 4) != 0) c = C_DISP_R;
         s = (($urandom % 8) == 0) ? 2 + int'($urandom % 2) : int'($urandom % 2);
         if (($urandom % 8) == 0) w = 8'($urandom);
         else w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         do_cmd(c, s, w, 0);
      end

      // CMD_REQ held high long after the ack
      load_ab(16'h4567, 16'h5544);
      do_cmd(C_ADD, 0, 8'h00, 20);
      do_cmd(C_DISP_R, 0, 8'h00, 0);
      check_eq("hold_r_lo", 32'(led), 32'h11);

      // Asynchronous reset in the middle of an ADD
      load_ab(16'h9999, 16'h0001);
      do_cmd(C_ADD, 0, 8'h00, 0);
      do_cmd(C_DISP_A, 1, 8'h00, 0);
      do_cmd(C_LOAD_A, 0, 8'hF0, 0);
      load_ab(16'h1234, 16'h4321);
      @(negedge clk);
      cmd = C_ADD; byte_sel = '0; sw = '0; cmd_req = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("arst_ack", 32'(cmd_ack), 32'd0);
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_led", 32'(led), 32'd0);
      check_eq("arst_carry", 32'(carry), 32'd0);
      check_eq("arst_err", 32'(err), 32'd0);
      @(negedge clk);
      cmd_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_cmd(C_DISP_R, 0, 8'h00, 0);
      check_eq("arst_r_lo", 32'(led), 32'h00);
      load_ab(16'h2758, 16'h3469);
      do_cmd(C_ADD, 0, 8'h00, 0);
      do_cmd(C_DISP_R, 0, 8'h00, 0);
      check_eq("post_rst_r_lo", 32'(led), 32'h27);
      do_cmd(C_DISP_R, 1, 8'h00, 0);
      check_eq("post_rst_r_hi", 32'(led), 32'h62);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_serial_alu.md
BCD_SERIAL_ALU -- requirements
Module: bcd_serial_alu

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the operand width in BCD digits; legal values are even numbers 2..16.
REQ-002 SHALL have parameter SELW, default 1, equal to max(1, clog2(DIGITS/2)), giving the byte-select width.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 SW  in  8  two BCD digits for a load (SW[7:4] is the more significant digit).
REQ-006 CMD  in  3  command: 0 INIT, 1 LOAD_A, 2 LOAD_B, 3 ADD, 4 SUB, 5 DISP_A, 6 DISP_B, 7 DISP_R.
REQ-007 BYTE_SEL  in  SELW  digit-pair index for load/display; 0 is the least significant pair.
REQ-008 CMD_REQ  in  1  four-phase command request.
REQ-009 CMD_ACK  out  1  four-phase command acknowledge.
REQ-010 LED  out  8  registered display byte.
REQ-011 BUSY  out  1  high whenever the FSM is not in IDLE.
REQ-012 CARRY  out  1  ADD: carry-out; SUB: borrow.
REQ-013 ERR  out  1  sticky error: invalid BCD load or out-of-range BYTE_SEL.

Function
REQ-014 SHALL hold internal registers A, B, R (each DIGITS x 4 bits) and a 4-state FSM: IDLE, EXEC, ARITH, ACKW.
REQ-015 In IDLE, on an edge k with CMD_REQ=1: SHALL capture CMD, BYTE_SEL and SW; go to ARITH for ADD/SUB, otherwise to EXEC.
REQ-016 EXEC SHALL perform its one action at edge k+1, set CMD_ACK=1 and go to ACKW.
REQ-017 ARITH SHALL process one digit per edge, least significant first, over DIGITS edges; at edge k+DIGITS it SHALL write the final digit, update CARRY, set CMD_ACK=1 and go to ACKW.
REQ-018 ACKW SHALL hold CMD_ACK=1 until an edge samples CMD_REQ=0; at that edge CMD_ACK=0 and the FSM returns to IDLE.
REQ-019 A command SHALL execute exactly once per request; holding CMD_REQ high SHALL NOT re-trigger it.
REQ-020 CMD, BYTE_SEL and SW changes after capture SHALL be ignored.
REQ-021 INIT SHALL clear A, B, R, LED, CARRY and ERR.
REQ-022 LOAD_A/LOAD_B SHALL write SW into digit pair BYTE_SEL of A/B.
REQ-023 If either SW nibble > 9, the load target SHALL be unchanged, ERR=1, and the command SHALL still be acknowledged.
REQ-024 DISP_A/B/R SHALL load LED with digit pair BYTE_SEL of A/B/R.
REQ-025 LED SHALL change only on DISP_* and INIT.
REQ-026 If BYTE_SEL >= DIGITS/2 on LOAD or DISP, SHALL make no register change, set ERR=1, and acknowledge.
REQ-027 ADD: each digit step d = A_i + B_i + c, carry-in 0.
  - If d > 9: R_i = d + 6 (low 4 bits) and c = 1.
  - Otherwise: R_i = d and c = 0.
  - CARRY = final c.
  - R = (A + B) mod 10^DIGITS.
REQ-028 SUB: each digit step d = A_i + (9 - B_i) + c, carry-in 1, with the same digit correction as ADD.
  - CARRY = NOT final c.
  - R = (A - B) mod 10^DIGITS (ten's complement when CARRY=1).
REQ-029 R SHALL be updated digit by digit during ARITH.
REQ-030 A, B, LED and ERR SHALL be unchanged by ADD/SUB.
REQ-031 Operand registers SHALL only ever hold valid BCD; arithmetic on them SHALL never produce a digit > 9.
REQ-032 ERR SHALL be cleared only by INIT or reset.

Reset
REQ-033 RST_N=0 SHALL immediately clear A, B, R, LED, CMD_ACK, BUSY, CARRY, ERR and the digit counter, and force IDLE, regardless of CLK.
REQ-034 Reset asserted during ARITH or ACKW SHALL abort the command; no partial R SHALL survive.
REQ-035 After RST_N rises, the first edge with CMD_REQ=1 SHALL be treated as a new request.

Verification (DIGITS=4)
REQ-036 Load A: SW=0x34/BYTE_SEL=0, then 0x12/1. Load B: 0x78/0, then 0x56/1. Issue ADD -> CMD_ACK at k+4; DISP_R sel0 gives LED=0x12, sel1 gives LED=0x69; CARRY=0.
REQ-037 A=9999, B=0001, ADD -> R=0000, CARRY=1. Then A=0100, B=0200, SUB -> R=9900, CARRY=1. Then SUB with A=0500, B=0123 -> R=0377, CARRY=0.
REQ-038 LOAD_A with SW=0x3A -> ERR=1, A unchanged, CMD_ACK still pulses. DISP_A with BYTE_SEL=2 (SELW=2 build variant) -> ERR=1, LED unchanged. INIT -> ERR=0.
REQ-039 Hold CMD_REQ high for 20 cycles after ADD -> single execution, CMD_ACK high until CMD_REQ drops, then low one edge later; BUSY high throughout.
REQ-040 Pulse RST_N low asynchronously mid-ARITH (digit 2 of 4) -> all outputs 0 and R=0 immediately; a subsequent ADD on reloaded operands gives a correct result.
